// File: rtl/vector_pack_pkg.sv
// Shared constants and state type for the vector pack unit.
// Mode encodings for conf_byte and the pack FSM state encoding.
package vector_pack_pkg;

  localparam logic [7:0] CONF_PASS = 8'd0;
  localparam logic [7:0] CONF_PACK = 8'd1;

  typedef enum logic {ST_IDLE, ST_FILL} pack_state_t;

endpackage

// File: rtl/vector_pack_unit.sv
// Packs lane-0 scalars of successive vectors into N-lane vectors, or passes vectors through.
// Optional feature: define VECTOR_PACK_COUNT_EN to add count_out (real lanes per output vector).
module vector_pack_unit
  import vector_pack_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_valid,
  input  logic [7:0]                     cfg_byte,
  input  logic                           valid_in,
  input  logic                           eof_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
  output logic                           valid_out,
  output logic                           eof_out,
  output logic [N-1:0][DATA_WIDTH-1:0]   vector_out,
`ifdef VECTOR_PACK_COUNT_EN
  output logic [$clog2(N):0]             count_out,
`endif
  output pack_state_t                    dbg_state
);

  localparam int CNT_W = $clog2(N);

  // Handshake: no backpressure. valid_in is consumed on every cycle it is high;
  // valid_out is a one-cycle pulse that downstream must accept unconditionally.

  logic [7:0]                   conf_byte;
  logic [CNT_W-1:0]             cnt;
  pack_state_t                  state, state_next;
  logic [N-1:0][DATA_WIDTH-1:0] pack_buf;
  logic [N-1:0][DATA_WIDTH-1:0] emit_vec;
  logic [N-1:0]                 lane_sel;
  logic                         pack_mode, last;
  logic                         do_store, do_emit, do_flush, do_eof_only;

  always_comb begin
    pack_mode   = (conf_byte == CONF_PACK);
    last        = (cnt == CNT_W'(N-1)) | eof_in;
    do_store    = pack_mode & valid_in & ~last;
    do_emit     = pack_mode & valid_in & last;
    do_flush    = pack_mode & ~valid_in & eof_in & (state == ST_FILL);
    do_eof_only = pack_mode & ~valid_in & eof_in & (state == ST_IDLE);

    state_next = state;
    if (do_store)
      state_next = ST_FILL;
    else if (do_emit | do_flush)
      state_next = ST_IDLE;

    // Lanes at and above cnt are already zero in pack_buf, so OR-ing in the
    // incoming scalar builds the zero-padded output directly.
    lane_sel = '0;
    emit_vec = '0;
    for (int i = 0; i < N; i++) begin
      lane_sel[i] = (cnt == CNT_W'(i));
      emit_vec[i] = pack_buf[i] | ((valid_in & lane_sel[i]) ? vector_in[0] : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conf_byte  <= CONF_PACK;
      cnt        <= '0;
      state      <= ST_IDLE;
      pack_buf   <= '0;
      valid_out  <= 1'b0;
      eof_out    <= 1'b0;
      vector_out <= '0;
    end else begin
      state     <= state_next;
      valid_out <= 1'b0;
      eof_out   <= 1'b0;
      // Mode changes only between vectors so a partial pack is never split.
      if (cfg_valid && cnt == '0 && !valid_in)
        conf_byte <= cfg_byte;
      if (!pack_mode) begin
        vector_out <= vector_in;
        valid_out  <= valid_in;
        eof_out    <= eof_in;
      end else if (do_store) begin
        for (int i = 0; i < N; i++)
          if (lane_sel[i]) pack_buf[i] <= vector_in[0];
        cnt <= cnt + CNT_W'(1);
      end else if (do_emit | do_flush) begin
        vector_out <= emit_vec;
        valid_out  <= 1'b1;
        eof_out    <= eof_in;
        cnt        <= '0;
        pack_buf   <= '0;
      end else if (do_eof_only) begin
        eof_out <= 1'b1;
      end
    end
  end

`ifdef VECTOR_PACK_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      count_out <= '0;
    else if (!pack_mode)
      count_out <= (CNT_W+1)'(N);
    else if (do_emit)
      count_out <= {1'b0, cnt} + (CNT_W+1)'(1);
    else if (do_flush)
      count_out <= {1'b0, cnt};
    else if (do_eof_only)
      count_out <= '0;
  end
`endif

  assign dbg_state = state;

endmodule
